pc_ras: RTL
===========

Name: pc_ras

Overview:
- Parametrised next-generation program counter for the LIPSI core, with an integrated return-address stack (RAS).
- Supports hold, increment, absolute jump, PC-relative branch, call and return, all selected by an encoded op.
- Sits between the control FSM, which drives op/target/offset, and instruction memory, which is addressed by pc_out.
- Reports stack occupancy and a sticky stack-error flag to the control unit.

Parameters:
- PC_W, 8, PC and target width in bits.
- OFF_W, 8, branch offset width; signed two's complement; constraint OFF_W <= PC_W.
- DEPTH, 4, RAS entries; constraint DEPTH >= 2.
- RESET_VEC, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  3  operation: 0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6/7 reserved.
- target  in  PC_W  absolute destination for JUMP and CALL.
- offset  in  OFF_W  signed displacement for BRANCH.
- err_clr  in  1  clears the sticky err flag.
- pc_out  out  PC_W  current program counter (registered).
- ras_depth  out  clog2(DEPTH+1)  number of valid RAS entries.
- ras_full  out  1  ras_depth == DEPTH.
- ras_empty  out  1  ras_depth == 0.
- err  out  1  sticky flag: set by a CALL when full or a RET when empty.

Behaviour:
- Reset (reset_n low, asynchronous): pc_out=RESET_VEC, ras_depth=0, ras_empty=1, ras_full=0, err=0. RAS contents are don't-care.
- Reset deassertion mid-program: the next op is evaluated on the first rising edge after reset_n goes high. No pending op survives reset.
- All updates take effect at the rising edge of clk; one op per cycle; single-cycle latency. The new pc_out is visible in the cycle after op is sampled.
- HOLD: no state change.
- INC: pc_out <= pc_out+1, modulo 2^PC_W; max value wraps to 0.
- JUMP: pc_out <= target.
- BRANCH: pc_out <= pc_out + sign_extend(offset), modulo 2^PC_W.
  - Offset is relative to the current pc_out, not pc+1.
  - offset = 0 behaves as HOLD.
- CALL, RAS not full: push (pc_out+1) mod 2^PC_W, ras_depth+1, pc_out <= target.
- CALL, RAS full: no push, pc_out holds, err <= 1.
- RET, RAS not empty: pop; pc_out <= top entry, ras_depth-1.
- RET, RAS empty: pc_out holds, err <= 1.
- Reserved ops (6, 7): treated as HOLD; err is not affected.
- err is sticky. err_clr=1 clears it at the next edge. If err_clr and a new error occur in the same cycle, the set wins and err=1.
- RAS is LIFO, storage index = ras_depth. ras_full and ras_empty are combinational decodes of the registered ras_depth.
- Back-to-back CALL/RET on consecutive cycles is fully supported. A RET in the cycle right after a CALL returns to that CALL's pc+1.
- target and offset are ignored for ops that do not use them.

Decomposition:
- Shared package pc_pkg holds:
  - the op encodings as named constants (OP_HOLD … OP_RET);
  - the op width (3).
- Sub-module ras_stack (parametrised by PC_W and DEPTH) holds the storage array and depth counter.
  - Inputs: push, pop, push_data.
  - Outputs: top, depth, full, empty.
  - pc_ras gates push and pop with full and empty and generates err.
- pc_ras contains the PC register, the next-PC mux and the err flag.

Test Plan:
- Reset then INC ×3 -> pc_out 0,1,2,3. Assert reset_n low mid-sequence (asynchronously) -> pc_out=0 immediately, ras_depth=0, err=0.
- pc_out=0xFE, INC ×2 -> 0xFF, then 0x00 (wrap). From 0x05, BRANCH offset=0xFB (−5) -> 0x00. From 0xF0, BRANCH offset=0x20 -> 0x10.
- Nested calls: pc=0x10 CALL 0x40; CALL 0x80; RET; RET.
  - pc_out sequence: 0x40, 0x80, 0x41, 0x11.
  - ras_depth sequence: 1, 2, 1, 0.
- Overflow (DEPTH=4): 4 CALLs then a 5th CALL 0x99 -> pc_out unchanged, ras_full=1, err=1, ras_depth=4. The following RET returns the 4th pushed address.
- Underflow: reset, RET -> pc_out=0, err=1. Assert err_clr -> err=0 next cycle. Assert err_clr together with another RET on empty -> err stays 1.
- Reserved op 6 and op 7 with arbitrary target/offset -> pc_out, ras_depth and err unchanged. JUMP 0xAA -> pc_out=0xAA, RAS untouched.

Source files
------------

// File: rtl/pc_ras_pkg.sv
// Shared op encodings for the LIPSI next-PC unit with return-address stack.
package pc_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = 3'd0;
    localparam logic [OP_W-1:0] OP_INC    = 3'd1;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd3;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd4;
    localparam logic [OP_W-1:0] OP_RET    = 3'd5;
endpackage

// File: rtl/pc_ras_if.sv
// Control-side bundle: op/target/offset in, PC and RAS status out.
interface pc_ras_if #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 8,
    parameter int DEPTH = 4
);
    import pc_pkg::*;
    localparam int DW = $clog2(DEPTH + 1);

    logic [OP_W-1:0]  op;
    logic [PC_W-1:0]  target;
    logic [OFF_W-1:0] offset;
    logic             err_clr;
    logic [PC_W-1:0]  pc_out;
    logic [DW-1:0]    ras_depth;
    logic             ras_full;
    logic             ras_empty;
    logic             err;

    modport master (
        output op, target, offset, err_clr,
        input  pc_out, ras_depth, ras_full, ras_empty, err
    );

    modport slave (
        input  op, target, offset, err_clr,
        output pc_out, ras_depth, ras_full, ras_empty, err
    );
endinterface

// File: rtl/pc_ras_stack.sv
// LIFO storage for return addresses; the depth counter doubles as the write index.
module ras_stack #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic [DW-1:0]   depth,
    output logic            full,
    output logic            empty
);
    logic [PC_W-1:0] mem [DEPTH];
    logic [DW-1:0]   top_idx;

    // Callers never push when full or pop when empty, so no guarding here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  depth <= '0;
        else if (push) depth <= depth + DW'(1);
        else if (pop)  depth <= depth - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[depth[IW-1:0]] <= push_data;
    end

    assign top_idx = depth - DW'(1);
    assign top     = mem[top_idx[IW-1:0]];
    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);
endmodule

// File: rtl/pc_ras.sv
// Next-PC register with hold/inc/jump/branch/call/ret and a sticky RAS error flag.
module pc_ras
    import pc_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              OFF_W     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic    clk,
    input  logic    reset_n,
    pc_ras_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, off_ext, top;
    logic [DW-1:0]   depth;
    logic            full, empty, push, pop, err_q, err_set;

    assign pc_inc  = pc_q + PC_W'(1);
    // Size cast of a signed operand sign-extends, and stays legal when OFF_W == PC_W.
    assign off_ext = PC_W'($signed(bus.offset));

    always_comb begin
        pc_nxt  = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (bus.op)
            OP_INC:    pc_nxt = pc_inc;
            OP_JUMP:   pc_nxt = bus.target;
            OP_BRANCH: pc_nxt = pc_q + off_ext;
            OP_CALL: begin
                if (full) err_set = 1'b1;
                else begin
                    push   = 1'b1;
                    pc_nxt = bus.target;
                end
            end
            OP_RET: begin
                if (empty) err_set = 1'b1;
                else begin
                    pop    = 1'b1;
                    pc_nxt = top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q <= pc_nxt;
            // A fresh error outranks a simultaneous clear.
            if (err_set)          err_q <= 1'b1;
            else if (bus.err_clr) err_q <= 1'b0;
        end
    end

    ras_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (top),
        .depth     (depth),
        .full      (full),
        .empty     (empty)
    );

    assign bus.pc_out    = pc_q;
    assign bus.ras_depth = depth;
    assign bus.ras_full  = full;
    assign bus.ras_empty = empty;
    assign bus.err       = err_q;
endmodule
